// File: rtl/pwm_ramp.sv
// rtl/pwm_ramp.sv - duty-cycle ramp generator producing hi/lo set-points for a downstream PWM counter
module pwm_ramp #(
    parameter int CNT_WIDTH = 8,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 srst_n,
    input  logic                 en,
    input  logic [CNT_WIDTH-1:0] period,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [CNT_WIDTH-1:0] cmd_target,
    input  logic [CNT_WIDTH-1:0] cmd_step,
    input  logic [DIV_WIDTH-1:0] cmd_interval,
    output logic [CNT_WIDTH-1:0] hi,
    output logic [CNT_WIDTH-1:0] lo,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STEP} state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] duty_q, duty_d;
    logic [CNT_WIDTH-1:0] tgt_q, tgt_d;
    logic [CNT_WIDTH-1:0] step_q, step_d;
    logic [DIV_WIDTH-1:0] ivl_q, ivl_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [CNT_WIDTH-1:0] hi_q, hi_d;
    logic [CNT_WIDTH-1:0] lo_q, lo_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 ready_q, ready_d;

    // Duty and target are pulled down to the live period every cycle so duty never exceeds it.
    logic [CNT_WIDTH-1:0] duty_c, tgt_c, cmd_tgt_eff, step_val, up_val, dn_val;
    logic [CNT_WIDTH:0]   sum_w, diff_w;
    logic                 accept, accept_hit, step_fire, step_hit;

    always_comb begin
        duty_c      = (duty_q > period) ? period : duty_q;
        tgt_c       = (tgt_q > period) ? period : tgt_q;
        cmd_tgt_eff = (cmd_target > period) ? period : cmd_target;
        accept      = cmd_valid && ready_q;
        accept_hit  = accept && (cmd_tgt_eff == duty_c);
        sum_w       = {1'b0, duty_c} + {1'b0, step_q};
        diff_w      = {1'b0, duty_c} - {1'b0, step_q};
        up_val      = (sum_w > {1'b0, tgt_c}) ? tgt_c : sum_w[CNT_WIDTH-1:0];
        dn_val      = (diff_w[CNT_WIDTH] || (diff_w[CNT_WIDTH-1:0] < tgt_c)) ? tgt_c
                                                                              : diff_w[CNT_WIDTH-1:0];
        if (duty_c < tgt_c)      step_val = up_val;
        else if (duty_c > tgt_c) step_val = dn_val;
        else                     step_val = duty_c;
        step_fire = (state_q == S_STEP) && en;
        step_hit  = step_fire && (step_val == tgt_c);
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            state_q <= S_IDLE;
            duty_q  <= '0;
            tgt_q   <= '0;
            step_q  <= '0;
            ivl_q   <= '0;
            div_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            tgt_q   <= tgt_d;
            step_q  <= step_d;
            ivl_q   <= ivl_d;
            div_q   <= div_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = accept_hit ? S_IDLE : S_WAIT;
            S_WAIT: begin
                if (accept)                       state_d = accept_hit ? S_IDLE : S_WAIT;
                else if (en && (div_q == '0))     state_d = S_STEP;
            end
            S_STEP: if (en) state_d = step_hit ? S_IDLE : S_WAIT;
            default: state_d = S_IDLE;
        endcase
    end

    // A command in WAIT restarts the divider but leaves duty where it is.
    always_comb begin
        duty_d = step_fire ? step_val : duty_c;
        tgt_d  = accept ? cmd_tgt_eff : tgt_c;
        step_d = accept ? ((cmd_step == '0) ? CNT_WIDTH'(1) : cmd_step) : step_q;
        ivl_d  = accept ? cmd_interval : ivl_q;
        div_d  = div_q;
        if (accept)
            div_d = cmd_interval;
        else if ((state_q == S_WAIT) && en && (div_q != '0))
            div_d = div_q - DIV_WIDTH'(1);
        else if (step_fire)
            div_d = ivl_q;
    end

    always_comb begin
        hi_d    = period - duty_d;
        lo_d    = period;
        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d != S_STEP);
        done_d  = accept_hit || step_hit;
    end

    assign cmd_ready = ready_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_pwm_ramp.sv
// tb/tb_pwm_ramp.sv - randomized bench for pwm_ramp against a behavioural ramp model
module tb_pwm_ramp;
    localparam int CW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          srst_n, en, cmd_valid, cmd_ready, busy, done;
    logic [CW-1:0] period, cmd_target, cmd_step, hi, lo;
    logic [DW-1:0] cmd_interval;

    always #5 clk = ~clk;

    pwm_ramp #(.CNT_WIDTH(CW), .DIV_WIDTH(DW)) dut (
        .clk(clk), .srst_n(srst_n), .en(en), .period(period),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_target(cmd_target),
        .cmd_step(cmd_step), .cmd_interval(cmd_interval),
        .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    int total = 0;
    int bad   = 0;

    // Model: duty moves once per (interval+2) enabled clocks after being armed.
    int m_duty = 0, m_tgt = 0, m_step = 0, m_ivl = 0, m_k = 0;
    bit m_act = 1'b0;
    int e_hi = 0, e_lo = 0, e_busy = 0, e_done = 0, e_ready = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_edge();
        int p;
        if (!srst_n) begin
            m_duty = 0; m_tgt = 0; m_step = 0; m_ivl = 0; m_k = 0; m_act = 1'b0;
            e_hi = 0; e_lo = 0; e_busy = 0; e_done = 0; e_ready = 0;
            return;
        end
        p      = int'(period);
        m_duty = imin(m_duty, p);
        m_tgt  = imin(m_tgt, p);
        e_done = 0;
        if (cmd_valid && e_ready != 0) begin
            m_tgt  = imin(int'(cmd_target), p);
            m_step = (cmd_step == 0) ? 1 : int'(cmd_step);
            m_ivl  = int'(cmd_interval);
            m_k    = 0;
            if (m_tgt == m_duty) begin
                m_act  = 1'b0;
                e_done = 1;
            end else begin
                m_act = 1'b1;
            end
        end else if (m_act && en) begin
            m_k++;
            if (m_k == m_ivl + 2) begin
                if (m_duty < m_tgt)      m_duty = imin(m_duty + m_step, m_tgt);
                else if (m_duty > m_tgt) m_duty = imax(m_duty - m_step, m_tgt);
                m_k = 0;
                if (m_duty == m_tgt) begin
                    m_act  = 1'b0;
                    e_done = 1;
                end
            end
        end
        e_hi    = p - m_duty;
        e_lo    = p;
        e_busy  = m_act ? 1 : 0;
        e_ready = (m_act && m_k == m_ivl + 1) ? 0 : 1;
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_eq("hi", 32'(hi), 32'(e_hi));
        check_eq("lo", 32'(lo), 32'(e_lo));
        check_eq("busy", 32'(busy), 32'(e_busy));
        check_eq("done", 32'(done), 32'(e_done));
        check_eq("cmd_ready", 32'(cmd_ready), 32'(e_ready));
    endtask

    task automatic send(input int tgt, input int stp, input int ivl);
        cmd_valid    = 1'b1;
        cmd_target   = CW'(tgt);
        cmd_step     = CW'(stp);
        cmd_interval = DW'(ivl);
        cycle();
        cmd_valid    = 1'b0;
    endtask

    int ndone;

    initial begin
        srst_n = 1'b0; en = 1'b1; period = 8'd100; cmd_valid = 1'b1;
        cmd_target = 8'd40; cmd_step = 8'd10; cmd_interval = 16'd3;
        @(negedge clk);
        cycle();
        cycle();
        check_eq("rst_hi", 32'(hi), 32'd0);
        check_eq("rst_ready", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b0;
        srst_n    = 1'b1;
        cycle();
        check_eq("rel_hi", 32'(hi), 32'd100);
        check_eq("rel_ready", 32'(cmd_ready), 32'd1);

        // Ramp up 0 -> 40 in steps of 10.
        send(40, 10, 3);
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (done === 1'b1) ndone++;
        end
        check_eq("up_hi_end", 32'(hi), 32'd60);
        check_eq("up_done_cnt", 32'(ndone), 32'd1);

        // Ramp down 40 -> 0 saturating without underflow.
        send(0, 15, 1);
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (done === 1'b1) ndone++;
        end
        check_eq("dn_hi_end", 32'(hi), 32'd100);
        check_eq("dn_done_cnt", 32'(ndone), 32'd1);

        // Target above period saturates, then lowering the period clamps duty.
        period = 8'd50;
        send(200, 20, 0);
        for (int i = 0; i < 12; i++) cycle();
        check_eq("sat_hi", 32'(hi), 32'd0);
        period = 8'd30;
        cycle();
        check_eq("clamp_hi", 32'(hi), 32'd0);
        check_eq("clamp_lo", 32'(lo), 32'd30);

        // Enable toggling every cycle during a ramp.
        period = 8'd100;
        send(0, 10, 3);
        for (int i = 0; i < 40; i++) begin
            en = ~en;
            cycle();
        end
        en = 1'b1;

        // Redirected ramp mid-flight, then zero-step command.
        send(80, 10, 1);
        for (int i = 0; i < 12; i++) cycle();
        send(10, 0, 0);
        for (int i = 0; i < 40; i++) cycle();

        for (int i = 0; i < 4000; i++) begin
            srst_n = ($urandom_range(0, 249) != 0);
            if ($urandom_range(0, 79) == 0) period = CW'($urandom_range(0, 255));
            en           = ($urandom_range(0, 5) != 0);
            cmd_valid    = ($urandom_range(0, 24) == 0);
            cmd_target   = CW'($urandom_range(0, 255));
            cmd_step     = CW'($urandom_range(0, 40));
            cmd_interval = DW'($urandom_range(0, 4));
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
